// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ
// valid/ready producers, holding each grant for at most MAX_BURST words.
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   parameter int ID_W      = 2
) (
   input  logic                      wr_clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      wr_full,
   output logic                      wr_en,
   output logic [DATA_W-1:0]         wr_data,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy
);

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic {
      IDLE,
      GRANT
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  burstCnt_q, burstCnt_d;
   logic [ID_W-1:0]   grantId_q, grantId_d;
   logic [ID_W-1:0]   lastGrant_q, lastGrant_d;

   logic [DATA_W-1:0] reqWord [NUM_REQ];
   logic              xfer;
   logic              found;
   logic [ID_W-1:0]   pick;
   logic [ID_W:0]     idx;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         reqWord[i] = req_data[i*DATA_W +: DATA_W];
      end
   end

   // Search starts one past the last grant; idx has a spare bit so the wrap is a single subtract.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = {1'b0, lastGrant_q} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(NUM_REQ)) begin
            idx = idx - (ID_W+1)'(NUM_REQ);
         end
         if (!found && req_valid[idx[ID_W-1:0]]) begin
            found = 1'b1;
            pick  = idx[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge wr_clk) begin
      if (reset) begin
         state_q     <= IDLE;
         burstCnt_q  <= '0;
         grantId_q   <= '0;
         lastGrant_q <= ID_W'(NUM_REQ-1);
      end else begin
         state_q     <= state_d;
         burstCnt_q  <= burstCnt_d;
         grantId_q   <= grantId_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      burstCnt_d  = burstCnt_q;
      grantId_d   = grantId_q;
      lastGrant_d = lastGrant_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grantId_d  = pick;
               burstCnt_d = '0;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            if (xfer) begin
               burstCnt_d = burstCnt_q + 1'b1;
               if (burstCnt_q == CNT_W'(MAX_BURST-1)) begin
                  state_d     = IDLE;
                  lastGrant_d = grantId_q;
               end
            end else if (!req_valid[grantId_q] && !wr_full) begin
               state_d     = IDLE;
               lastGrant_d = grantId_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset gates the handshake combinationally so nothing is written in the reset cycle.
   always_comb begin
      req_ready = '0;
      wr_data   = '0;
      xfer      = 1'b0;
      busy      = (state_q == GRANT);
      grant_id  = grantId_q;
      if (state_q == GRANT) begin
         wr_data = reqWord[grantId_q];
         if (!reset) begin
            req_ready[grantId_q] = !wr_full;
            xfer                 = req_valid[grantId_q] & !wr_full;
         end
      end
      wr_en = xfer;
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, every cycle compared against a transaction-level reference model.
module tb_fifo_wr_arbiter;

   localparam int NREQ = 4;
   localparam int MAXB = 4;

   logic        clk;
   logic        reset;
   logic [3:0]  vld;
   logic [31:0] reqData;
   logic [3:0]  ready;
   logic        full;
   logic        wrEn;
   logic [7:0]  wrData;
   logic [1:0]  grantId;
   logic        busy;

   fifo_wr_arbiter #(
      .NUM_REQ(NREQ), .DATA_W(8), .MAX_BURST(MAXB), .ID_W(2)
   ) dut (
      .wr_clk(clk), .reset(reset), .req_valid(vld), .req_data(reqData),
      .req_ready(ready), .wr_full(full), .wr_en(wrEn), .wr_data(wrData),
      .grant_id(grantId), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;
   int seq [NREQ];
   int owner, taken, lastG, gid;
   int obsWrites, burstObs;
   bit prevBusy;
   int grantLog [$];

   task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   function automatic logic [7:0] wordOf(input int r, input int s);
      return 8'((r << 4) + (s & 15));
   endfunction

   // One cycle: drive producer data, compare outputs with the model, then advance the model.
   task automatic applyStimulus();
      logic [3:0] expReady;
      bit         xf;
      for (int i = 0; i < NREQ; i++) reqData[i*8 +: 8] = wordOf(i, seq[i]);
      #1;
      xf       = (owner >= 0) && vld[owner] && !full && !reset;
      expReady = '0;
      if (owner >= 0 && !full && !reset) expReady[owner] = 1'b1;
      checkOutput("busy", 32'(busy), 32'(owner >= 0));
      checkOutput("grantId", 32'(grantId), 32'(gid));
      checkOutput("wrEn", 32'(wrEn), 32'(xf));
      checkOutput("ready", 32'(ready), 32'(expReady));
      checkOutput("wrData", 32'(wrData), (owner >= 0) ? 32'(wordOf(owner, seq[owner])) : 32'd0);

      if (!busy) burstObs = 0;
      if (wrEn) begin
         obsWrites++;
         burstObs++;
         checkOutput("burstLen", 32'(burstObs <= MAXB), 32'd1);
      end
      if (busy && !prevBusy) grantLog.push_back(int'(grantId));
      prevBusy = busy;

      if (reset) begin
         owner = -1; taken = 0; lastG = NREQ - 1; gid = 0;
      end else if (owner < 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (lastG + k) % NREQ;
            if (owner < 0 && vld[c]) begin
               owner = c; gid = c; taken = 0;
            end
         end
      end else if (xf) begin
         seq[owner]++;
         taken++;
         if (taken == MAXB) begin
            lastG = owner; owner = -1;
         end
      end else if (!vld[owner] && !full) begin
         lastG = owner; owner = -1;
      end
      @(negedge clk);
   endtask

   task automatic doReset();
      reset = 1'b1;
      vld   = '0;
      full  = 1'b0;
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      for (int i = 0; i < NREQ; i++) seq[i] = 0;
      obsWrites = 0;
      grantLog.delete();
   endtask

   initial begin
      int g0, g1;
      reset = 1'b1; vld = '0; full = 1'b0; reqData = '0;
      owner = -1; taken = 0; lastG = NREQ - 1; gid = 0;
      obsWrites = 0; burstObs = 0; prevBusy = 1'b0;
      for (int i = 0; i < NREQ; i++) seq[i] = 0;
      @(negedge clk);

      // Lone requester streaming six words: burst of four, one idle cycle, then two more.
      doReset();
      for (int c = 0; c < 12; c++) begin
         vld = (seq[0] < 6) ? 4'b0001 : 4'b0000;
         applyStimulus();
      end
      checkOutput("t1Writes", 32'(obsWrites), 32'd6);

      // All four continuously valid: 16 writes in 20 cycles, grant order 0,1,2,3,0.
      doReset();
      vld = 4'b1111;
      for (int c = 0; c < 20; c++) applyStimulus();
      checkOutput("t2Writes", 32'(obsWrites), 32'd16);
      for (int c = 0; c < 2; c++) applyStimulus();
      checkOutput("t2Grants", 32'(grantLog.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         g0 = (grantLog.size() > i) ? grantLog[i] : -1;
         checkOutput("t2Order", 32'(g0), 32'(i % NREQ));
      end

      // Requester 2 stalled by wr_full after its second word; burst still ends at four.
      doReset();
      vld = 4'b0100;
      for (int c = 0; c < 9; c++) begin
         full = (c >= 3 && c <= 5);
         applyStimulus();
      end
      full = 1'b0;
      checkOutput("t3Writes", 32'(obsWrites), 32'd4);

      // Requester 1 drops valid after two words; requester 3 is next.
      doReset();
      for (int c = 0; c < 8; c++) begin
         vld = {1'b1, 1'b0, (seq[1] < 2), 1'b0};
         applyStimulus();
      end
      g0 = (grantLog.size() > 0) ? grantLog[0] : -1;
      g1 = (grantLog.size() > 1) ? grantLog[1] : -1;
      checkOutput("t4First", 32'(g0), 32'd1);
      checkOutput("t4Second", 32'(g1), 32'd3);
      checkOutput("t4Writes1", 32'(seq[1]), 32'd2);

      // Reset during requester 2's second word; afterwards 2 and 3 valid, 2 wins.
      doReset();
      vld = 4'b0100;
      applyStimulus();
      applyStimulus();
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      vld = 4'b1100;
      grantLog.delete();
      for (int c = 0; c < 3; c++) applyStimulus();
      g0 = (grantLog.size() > 0) ? grantLog[0] : -1;
      checkOutput("t5Grant", 32'(g0), 32'd2);

      // Random traffic, valid may retract, wr_full asserted about a quarter of the time.
      doReset();
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (vld[i]) vld[i] = ($urandom_range(7) != 0);
            else        vld[i] = ($urandom_range(1) == 1);
         end
         full = ($urandom_range(3) == 0);
         applyStimulus();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
